// File: rtl/tocador_pkg.sv
// Shared definitions for the note player.
//   estado_t      : FSM state encoding (OCIOSO=00, TOCANDO=01, PAUSA=10; 11 unused)
//   NOTA_*        : 3-bit note codes received from the game controller
//   meio_periodo  : half period, in 50 MHz clock cycles, of each octave-4 note
package tocador_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        TOCANDO = 2'b01,
        PAUSA   = 2'b10
    } estado_t;

    localparam logic [2:0] NOTA_SILENCIO = 3'd0;
    localparam logic [2:0] NOTA_DO       = 3'd1;
    localparam logic [2:0] NOTA_RE       = 3'd2;
    localparam logic [2:0] NOTA_MI       = 3'd3;
    localparam logic [2:0] NOTA_FA       = 3'd4;
    localparam logic [2:0] NOTA_SOL      = 3'd5;
    localparam logic [2:0] NOTA_LA       = 3'd6;
    localparam logic [2:0] NOTA_SI       = 3'd7;

    // Unscaled half period for a note code; the rest code returns 0.
    // The caller applies any shift and clamps the result to at least 1.
    function automatic logic [16:0] meio_periodo(input logic [2:0] code);
        logic [16:0] v;
        case (code)
            NOTA_DO:  v = 17'd95420;
            NOTA_RE:  v = 17'd85034;
            NOTA_MI:  v = 17'd75758;
            NOTA_FA:  v = 17'd71633;
            NOTA_SOL: v = 17'd63776;
            NOTA_LA:  v = 17'd56818;
            NOTA_SI:  v = 17'd50607;
            default:  v = 17'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/tocador_notas_if.sv
// Note-code link between the game controller and the note player.
//   nota, activate           : controller -> player (code + 1-cycle start strobe)
//   buzzer                   : square-wave output for the piezo
//   tocando, fim             : player -> controller (busy, end-of-note pulse)
//   db_nota, db_estado       : debug view of the latched code and FSM state
// Modports: master = game controller side, slave = note player side.
interface tocador_notas_if;
    logic [2:0] nota;
    logic       activate;
    logic       buzzer;
    logic       tocando;
    logic       fim;
    logic [2:0] db_nota;
    logic [1:0] db_estado;

    modport master (
        output nota, activate,
        input  buzzer, tocando, fim, db_nota, db_estado
    );

    modport slave (
        input  nota, activate,
        output buzzer, tocando, fim, db_nota, db_estado
    );
endinterface

// File: rtl/divisor_tom.sv
// Tone divider: half-period down-counter plus the square-wave toggle flop.
//   clock    : system clock
//   reset    : asynchronous active-low reset
//   carrega  : load counter with meio-1 and force the wave low (note start)
//   meio     : half period in cycles (>= 1), held stable while counting
//   habilita : count and toggle; when low (and not loading) the wave is held low
//   onda     : square-wave output
module divisor_tom (
    input  logic        clock,
    input  logic        reset,
    input  logic        carrega,
    input  logic [16:0] meio,
    input  logic        habilita,
    output logic        onda
);

    logic [16:0] cont_reg;
    logic        onda_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cont_reg <= '0;
            onda_reg <= 1'b0;
        end else if (carrega) begin
            cont_reg <= meio - 17'd1;
            onda_reg <= 1'b0;
        end else if (habilita) begin
            if (cont_reg == 17'd0) begin
                cont_reg <= meio - 17'd1;
                onda_reg <= ~onda_reg;
            end else begin
                cont_reg <= cont_reg - 17'd1;
            end
        end else begin
            // Rest note, last note cycle, gap and idle all keep the pin quiet.
            onda_reg <= 1'b0;
        end
    end

    assign onda = onda_reg;

endmodule

// File: rtl/tocador_notas.sv
// Note player: accepts a 3-bit note code on an activate strobe, plays it as a
// square wave for DUR_CYC cycles, then stays silent for GAP_CYC cycles.
//   clock   : system clock (50 MHz)
//   reset   : asynchronous active-low reset
//   bus     : tocador_notas_if.slave (nota/activate in; buzzer, tocando,
//             fim, db_nota, db_estado out)
// Parameters: DUR_CYC (note cycles), GAP_CYC (gap cycles), DIV_SHIFT (right
// shift of the half-period table, clamped to >= 1).
// Optional build macro TOCADOR_RETRIGGER_EN: activate during a note or its gap
// restarts with the new code; without it such strobes are ignored.
module tocador_notas
    import tocador_pkg::*;
#(
    parameter int DUR_CYC   = 25_000_000,
    parameter int GAP_CYC   = 2_500_000,
    parameter int DIV_SHIFT = 0
) (
    input  logic            clock,
    input  logic            reset,
    tocador_notas_if.slave  bus
);

    localparam logic [24:0] DUR_INI = 25'(DUR_CYC - 1);
    localparam logic [24:0] GAP_INI = 25'(GAP_CYC - 1);

    estado_t     estado_reg, estado_next;
    logic [24:0] dur_reg, dur_next;
    logic [24:0] gap_reg, gap_next;
    logic [2:0]  nota_reg, nota_next;
    logic        fim_reg, fim_next;

    logic        aceita;
    logic        carrega;
    logic        habilita;
    logic [16:0] meio;
    logic        onda;

    function automatic logic [16:0] meio_escalado(input logic [2:0] code);
        logic [16:0] v;
        v = meio_periodo(code) >> DIV_SHIFT;
        if (v == 17'd0) v = 17'd1;
        return v;
    endfunction

`ifdef TOCADOR_RETRIGGER_EN
    assign aceita = bus.activate && (estado_reg inside {OCIOSO, TOCANDO, PAUSA});
`else
    assign aceita = bus.activate && (estado_reg == OCIOSO);
`endif

    // On the load cycle the divider must see the incoming code; afterwards the latched one.
    assign meio = carrega ? meio_escalado(bus.nota) : meio_escalado(nota_reg);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_reg <= OCIOSO;
            dur_reg    <= '0;
            gap_reg    <= '0;
            nota_reg   <= '0;
            fim_reg    <= 1'b0;
        end else begin
            estado_reg <= estado_next;
            dur_reg    <= dur_next;
            gap_reg    <= gap_next;
            nota_reg   <= nota_next;
            fim_reg    <= fim_next;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        dur_next    = dur_reg;
        gap_next    = gap_reg;
        nota_next   = nota_reg;
        fim_next    = 1'b0;
        carrega     = 1'b0;
        habilita    = 1'b0;

        if (aceita) begin
            estado_next = TOCANDO;
            dur_next    = DUR_INI;
            gap_next    = '0;
            nota_next   = bus.nota;
            carrega     = 1'b1;
        end else begin
            case (estado_reg)
                OCIOSO: begin
                end
                TOCANDO: begin
                    if (dur_reg == 25'd0) begin
                        // habilita stays low here so the wave drops for the gap.
                        estado_next = PAUSA;
                        gap_next    = GAP_INI;
                    end else begin
                        dur_next = dur_reg - 25'd1;
                        habilita = (nota_reg != NOTA_SILENCIO);
                    end
                end
                PAUSA: begin
                    if (gap_reg == 25'd0) begin
                        estado_next = OCIOSO;
                        nota_next   = NOTA_SILENCIO;
                        fim_next    = 1'b1;
                    end else begin
                        gap_next = gap_reg - 25'd1;
                    end
                end
                default: begin
                    // Unused encoding 11: fall back to idle without a fim pulse.
                    estado_next = OCIOSO;
                    nota_next   = NOTA_SILENCIO;
                    dur_next    = '0;
                    gap_next    = '0;
                end
            endcase
        end
    end

    divisor_tom u_divisor (
        .clock    (clock),
        .reset    (reset),
        .carrega  (carrega),
        .meio     (meio),
        .habilita (habilita),
        .onda     (onda)
    );

    assign bus.buzzer    = onda;
    assign bus.tocando   = (estado_reg == TOCANDO) || (estado_reg == PAUSA);
    assign bus.fim       = fim_reg;
    assign bus.db_nota   = nota_reg;
    assign bus.db_estado = estado_reg;

endmodule

// File: tb/tb_tocador_notas.sv
// Self-checking bench for tocador_notas with DUR_CYC=40, GAP_CYC=4, DIV_SHIFT=14.
// Expected per-cycle output records {buzzer,tocando,fim,db_nota,db_estado} are
// queued when a note is started and compared on each falling clock edge.
module tb_tocador_notas;

    localparam int DUR = 40;
    localparam int GAP = 4;

    logic clk;
    logic rst_n;

    tocador_notas_if bus ();

    tocador_notas #(
        .DUR_CYC   (DUR),
        .GAP_CYC   (GAP),
        .DIV_SHIFT (14)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Half periods after the >>14 scaling (code 0 unused: rest is silent).
    int half_tb [8] = '{0, 5, 5, 4, 4, 3, 3, 3};

    logic [7:0] exp_q [$];

    function automatic logic [7:0] obs();
        return {bus.buzzer, bus.tocando, bus.fim, bus.db_nota, bus.db_estado};
    endfunction

    // Queue the first len cycles (cycle k+1 onward) of a note accepted at edge k.
    task automatic push_note(input int n, input int len);
        logic bz;
        for (int j = 1; j <= len; j++) begin
            if (j <= DUR) begin
                bz = (n != 0) ? ((((j - 1) / half_tb[n]) % 2) != 0) : 1'b0;
                exp_q.push_back({bz, 1'b1, 1'b0, 3'(n), 2'b01});
            end else if (j <= DUR + GAP) begin
                exp_q.push_back({1'b0, 1'b1, 1'b0, 3'(n), 2'b10});
            end else begin
                exp_q.push_back({1'b0, 1'b0, 1'b1, 3'd0, 2'b00});
            end
        end
    endtask

    task automatic push_idle(input int c);
        for (int j = 0; j < c; j++) exp_q.push_back(8'h00);
    endtask

    task automatic test_reset;
        logic [7:0] o;
        bus.nota = 3'd0;
        bus.activate = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        o = obs();
        checks++;
        if (o !== 8'h00) begin
            fails++;
            $display("FAIL reset_async got %b want %b", o, 8'h00);
        end else passes++;
        // activate during reset must not be remembered
        @(negedge clk);
        bus.nota = 3'd5;
        bus.activate = 1'b1;
        @(negedge clk);
        @(negedge clk);
        o = obs();
        checks++;
        if (o !== 8'h00) begin
            fails++;
            $display("FAIL reset_hold got %b want %b", o, 8'h00);
        end else passes++;
        bus.activate = 1'b0;
        rst_n = 1'b1;
        push_idle(4);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            o = obs();
            checks++;
            if (o !== exp_q[0]) begin
                fails++;
                $display("FAIL reset_idle got %b want %b", o, exp_q[0]);
            end else passes++;
            void'(exp_q.pop_front());
            @(negedge clk);
        end
        $display("reset released, idle");
    endtask

    task automatic test_note(input int n, input string nome);
        logic [7:0] e, o;
        int j;
        push_note(n, DUR + GAP + 1);
        push_idle(3);
        bus.nota = 3'(n);
        bus.activate = 1'b1;
        $display("%s: note %0d started", nome, n);
        @(negedge clk);
        j = 1;
        while (exp_q.size() > 0) begin
            bus.activate = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s cycle k+%0d got %b want %b", nome, j, o, e);
            end else passes++;
            j++;
            @(negedge clk);
        end
    endtask

    task automatic test_half_periods;
        logic [7:0] e, o;
        int j, run, first_run, pausa_bz;
        int codes [2] = '{1, 7};
        for (int r = 0; r < 2; r++) begin
            push_note(codes[r], DUR + GAP + 1);
            push_idle(2);
            bus.nota = 3'(codes[r]);
            bus.activate = 1'b1;
            $display("half: note %0d started", codes[r]);
            @(negedge clk);
            j = 1; run = 0; first_run = -1; pausa_bz = 0;
            while (exp_q.size() > 0) begin
                bus.activate = 1'b0;
                e = exp_q.pop_front();
                o = obs();
                checks++;
                if (o !== e) begin
                    fails++;
                    $display("FAIL half_trace cycle k+%0d got %b want %b", j, o, e);
                end else passes++;
                if (o[7] === 1'b1) run++;
                else if (run > 0 && first_run < 0) first_run = run;
                if (o[1:0] == 2'b10 && o[7] !== 1'b0) pausa_bz++;
                j++;
                @(negedge clk);
            end
            checks++;
            if (first_run !== half_tb[codes[r]]) begin
                fails++;
                $display("FAIL half_period note %0d got %0d want %0d", codes[r], first_run, half_tb[codes[r]]);
            end else passes++;
            checks++;
            if (pausa_bz !== 0) begin
                fails++;
                $display("FAIL pausa_silent note %0d got %0d want 0", codes[r], pausa_bz);
            end else passes++;
        end
    endtask

    task automatic test_retrigger;
        logic [7:0] e, o;
        int j;
`ifdef TOCADOR_RETRIGGER_EN
        push_note(4, 10);
        push_note(2, DUR + GAP + 1);
`else
        push_note(4, DUR + GAP + 1);
`endif
        push_idle(3);
        bus.nota = 3'd4;
        bus.activate = 1'b1;
        $display("retrigger: note 4 started, note 2 strobed at k+10");
        @(negedge clk);
        j = 1;
        while (exp_q.size() > 0) begin
            bus.activate = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL retrigger cycle k+%0d got %b want %b", j, o, e);
            end else passes++;
            if (j == 10) begin
                bus.nota = 3'd2;
                bus.activate = 1'b1;
            end
            j++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e, o;
        int j, low_cnt;
        push_note(3, DUR + GAP + 1);
        push_note(5, DUR + GAP + 1);
        push_idle(2);
        bus.nota = 3'd3;
        bus.activate = 1'b1;
        $display("back_to_back: note 3 then note 5 on fim");
        @(negedge clk);
        j = 1; low_cnt = 0;
        while (exp_q.size() > 0) begin
            bus.activate = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL back_to_back cycle k+%0d got %b want %b", j, o, e);
            end else passes++;
            if (j <= 2 * (DUR + GAP) + 1 && o[6] !== 1'b1) low_cnt++;
            if (j == DUR + GAP + 1) begin
                bus.nota = 3'd5;
                bus.activate = 1'b1;
            end
            j++;
            @(negedge clk);
        end
        checks++;
        if (low_cnt !== 1) begin
            fails++;
            $display("FAIL b2b_low_gap got %0d want 1", low_cnt);
        end else passes++;
    endtask

    task automatic test_reset_mid_note;
        logic [7:0] e, o;
        int j;
        push_note(7, 15);
        bus.nota = 3'd7;
        bus.activate = 1'b1;
        $display("reset_mid: note 7 started, reset at k+16");
        @(negedge clk);
        j = 1;
        while (exp_q.size() > 0) begin
            bus.activate = 1'b0;
            e = exp_q.pop_front();
            o = obs();
            checks++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset_mid cycle k+%0d got %b want %b", j, o, e);
            end else passes++;
            j++;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        o = obs();
        checks++;
        if (o !== 8'h00) begin
            fails++;
            $display("FAIL reset_mid_async got %b want %b", o, 8'h00);
        end else passes++;
        bus.nota = 3'd6;
        bus.activate = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.activate = 1'b0;
        #2 rst_n = 1'b1;
        push_idle(6);
        @(negedge clk);
        while (exp_q.size() > 0) begin
            o = obs();
            checks++;
            if (o !== exp_q[0]) begin
                fails++;
                $display("FAIL reset_mid_idle got %b want %b", o, exp_q[0]);
            end else passes++;
            void'(exp_q.pop_front());
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_note(6, "tone6");
        test_note(0, "rest");
        test_half_periods();
        test_retrigger();
        test_back_to_back();
        test_reset_mid_note();
        test_note(2, "after_reset");
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
